// File: rtl/session_pkg.sv
// rtl/session_pkg.sv - shared state codes and width defaults for session_ctrl
package session_pkg;

    localparam int BLK_W_DEF      = 64;
    localparam int KEY_W_DEF      = 164;
    localparam int DEPTH_DEF      = 8;
    localparam int CIPHER_LAT_DEF = 3;

    // Enum values double as the externally visible mode codes.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYGEN = 3'd1,
        ST_READY  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && (r_count != (AW+1)'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage array; head entry is never overwritten while occupied.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/session_ctrl.sv
// rtl/session_ctrl.sv - session key handshake and ECB/CBC block streaming around a fixed-latency cipher core
module session_ctrl import session_pkg::*; #(
    parameter int BLK_W      = BLK_W_DEF,
    parameter int KEY_W      = KEY_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int CIPHER_LAT = CIPHER_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_encrypt,
    input  logic               cbc_en,
    input  logic [BLK_W-1:0]   iv,
    output logic               ecc_start,
    input  logic               ecc_done,
    input  logic [2*KEY_W-1:0] ecc_sk,
    output logic               cip_valid,
    output logic [BLK_W-1:0]   cip_in,
    output logic [2*KEY_W-1:0] cip_key,
    output logic               cip_encrypt,
    input  logic [BLK_W-1:0]   cip_out,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLK_W-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLK_W-1:0]   out_data,
    output logic               key_valid,
    output logic               err,
    output logic [2:0]         mode
);
    localparam int CW = $clog2(DEPTH) + 1;
    // All pipe stages except the tail, which is delivering its result this cycle.
    localparam logic [CIPHER_LAT-1:0] HEAD_MASK = {CIPHER_LAT{1'b1}} >> 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_enc;
    logic                 r_cbc;
    logic                 r_ecc_start;
    logic                 r_err;
    logic                 r_key_valid;
    logic [2*KEY_W-1:0]   r_key;
    logic [BLK_W-1:0]     r_chain;
    logic                 r_cip_valid;
    logic [BLK_W-1:0]     r_cip_in;
    logic [BLK_W-1:0]     r_cip_x;
    logic [CIPHER_LAT-1:0] r_vpipe;
    logic [BLK_W-1:0]     r_xpipe [CIPHER_LAT];
    logic [CW-1:0]        r_inflight;
    logic [CW-1:0]        w_count;
    logic [CW:0]          w_total;
    logic                 w_start_ok;
    logic                 w_key_ok;
    logic                 w_key_bad;
    logic                 w_cbc_enc;
    logic                 w_cbc_dec;
    logic                 w_tail;
    logic                 w_busy;
    logic                 w_acc;
    logic                 w_pop;
    logic [BLK_W-1:0]     w_chain;
    logic [BLK_W-1:0]     w_push_data;

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_READY);
    assign w_key_ok   = (r_state == ST_KEYGEN) && ecc_done && (ecc_sk != '0);
    assign w_key_bad  = (r_state == ST_KEYGEN) && ecc_done && (ecc_sk == '0);
    assign w_cbc_enc  = r_cbc && r_enc;
    assign w_cbc_dec  = r_cbc && !r_enc;
    assign w_tail     = r_vpipe[CIPHER_LAT-1];
    assign w_busy     = r_cip_valid || (|(r_vpipe & HEAD_MASK));
    assign w_total    = {1'b0, w_count} + {1'b0, r_inflight};
    assign in_ready   = (r_state == ST_STREAM) && (w_total < (CW+1)'(DEPTH)) &&
                        !(w_cbc_enc && w_busy);
    assign w_acc      = in_valid && in_ready;
    // CBC encrypt accepts the next block in the cycle the previous ciphertext emerges.
    assign w_chain     = (w_cbc_enc && w_tail) ? cip_out : r_chain;
    assign w_push_data = w_cbc_dec ? (cip_out ^ r_xpipe[CIPHER_LAT-1]) : cip_out;
    assign out_valid   = (w_count != '0);
    assign w_pop       = out_valid && out_ready;

    assign ecc_start   = r_ecc_start;
    assign err         = r_err;
    assign key_valid   = r_key_valid;
    assign cip_key     = r_key;
    assign cip_encrypt = r_enc;
    assign cip_valid   = r_cip_valid;
    assign cip_in      = r_cip_in;
    assign mode        = r_state;

    // Session state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode for the session lifecycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_KEYGEN;
            ST_KEYGEN: begin
                if (w_key_ok)       w_state_nxt = ST_READY;
                else if (w_key_bad) w_state_nxt = ST_IDLE;
            end
            ST_READY:  if (start) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_acc && in_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (r_inflight == '0 && w_count == '0) w_state_nxt = ST_READY;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Session parameters, key latch, handshake pulses and the CBC chaining value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ecc_start <= 1'b0;
            r_err       <= 1'b0;
            r_key_valid <= 1'b0;
            r_key       <= '0;
            r_enc       <= 1'b0;
            r_cbc       <= 1'b0;
            r_chain     <= '0;
        end else begin
            r_ecc_start <= start && (r_state == ST_IDLE);
            r_err       <= w_key_bad;
            if (w_start_ok) begin
                r_enc <= is_encrypt;
                r_cbc <= cbc_en;
            end
            if (w_key_ok) begin
                r_key       <= ecc_sk;
                r_key_valid <= 1'b1;
            end else if (w_key_bad) begin
                r_key_valid <= 1'b0;
            end
            if (w_start_ok)                r_chain <= iv;
            else if (w_cbc_enc && w_tail)  r_chain <= cip_out;
            else if (w_cbc_dec && w_acc)   r_chain <= in_data;
        end
    end

    // In-flight tracking: valid shift register mirrors the core latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cip_valid <= 1'b0;
            r_vpipe     <= '0;
            r_inflight  <= '0;
        end else begin
            r_cip_valid <= w_acc;
            r_vpipe[0]  <= r_cip_valid;
            for (int i = 1; i < CIPHER_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
            r_inflight  <= r_inflight + CW'(w_acc) - CW'(w_tail);
        end
    end

    // Block datapath: core input plus the previous ciphertext riding alongside for CBC decrypt.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_cip_in <= w_cbc_enc ? (in_data ^ w_chain) : in_data;
            r_cip_x  <= r_chain;
        end
        r_xpipe[0] <= r_cip_x;
        for (int i = 1; i < CIPHER_LAT; i++) r_xpipe[i] <= r_xpipe[i-1];
    end

    sync_fifo #(
        .W     (BLK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tail),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_session_ctrl.sv
// tb/tb_session_ctrl.sv - directed self-checking bench for session_ctrl
`timescale 1ns/1ps
module tb_session_ctrl;
    localparam int BLK_W = 64;
    localparam int KEY_W = 164;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;
    localparam logic [2*KEY_W-1:0] KEY_A =
        {164'h0_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA,
         164'h0_BBBB_CCCC_DDDD_EEEE_FFFF_0123_4567_89AB_CDEF_0F1E};
    localparam logic [63:0] IV_A   = 64'h0123456789ABCDEF;
    localparam logic [63:0] MASK_A = 64'hA5A50F0F5A5AF0F0;

    logic               clk, rst, start, is_encrypt, cbc_en;
    logic [BLK_W-1:0]   iv;
    logic               ecc_start, ecc_done;
    logic [2*KEY_W-1:0] ecc_sk, cip_key;
    logic               cip_valid, cip_encrypt;
    logic [BLK_W-1:0]   cip_in, cip_out;
    logic               in_valid, in_ready, in_last;
    logic [BLK_W-1:0]   in_data;
    logic               out_valid, out_ready;
    logic [BLK_W-1:0]   out_data;
    logic               key_valid, err;
    logic [2:0]         mode;

    int total = 0;
    int bad   = 0;

    logic [63:0] tx_q[$];
    logic [63:0] rx_q[$];
    int          acc_cyc[$];
    int          out_cyc[$];
    logic [63:0] core_d [LAT];
    logic [63:0] core_mask;
    logic [63:0] cbc_p [4];
    logic [63:0] cbc_c [4];

    session_ctrl #(.BLK_W(BLK_W), .KEY_W(KEY_W), .DEPTH(DEPTH), .CIPHER_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .is_encrypt(is_encrypt), .cbc_en(cbc_en), .iv(iv),
        .ecc_start(ecc_start), .ecc_done(ecc_done), .ecc_sk(ecc_sk),
        .cip_valid(cip_valid), .cip_in(cip_in), .cip_key(cip_key), .cip_encrypt(cip_encrypt),
        .cip_out(cip_out), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_valid(key_valid), .err(err), .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cipher core stand-in: XOR with core_mask, result LAT cycles after cip_valid.
    always @(posedge clk) begin
        core_d[0] <= cip_in ^ core_mask;
        for (int i = 1; i < LAT; i++) core_d[i] <= core_d[i-1];
    end
    assign cip_out = core_d[LAT-1];

    task automatic session_start(input logic enc, input logic cbc, input logic [63:0] v);
        start = 1'b1; is_encrypt = enc; cbc_en = cbc; iv = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives tx_q[0..n-1] and collects outputs; out_ready held low for the first hold cycles.
    task automatic stream_blocks(input int n, input int hold, input int budget);
        int sent = 0;
        int cyc  = 0;
        rx_q.delete(); acc_cyc.delete(); out_cyc.delete();
        while ((sent < n || rx_q.size() < n) && cyc < budget) begin
            in_valid  = (sent < n);
            in_data   = (sent < n) ? tx_q[sent] : 64'h0;
            in_last   = (sent == n - 1);
            out_ready = (cyc >= hold);
            #1;
            if (in_valid && in_ready) begin acc_cyc.push_back(cyc); sent++; end
            if (out_valid && out_ready) begin rx_q.push_back(out_data); out_cyc.push_back(cyc); end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    endtask

    task automatic wait_mode(input logic [2:0] m, input int budget);
        for (int k = 0; k < budget && mode !== m; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (mode !== 3'd0) begin bad++; $display("FAIL reset_mode: got %0d want 0", mode); end
        total++; if (ecc_start !== 1'b0) begin bad++; $display("FAIL reset_ecc_start: got %b want 0", ecc_start); end
        total++; if (cip_valid !== 1'b0) begin bad++; $display("FAIL reset_cip_valid: got %b want 0", cip_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (cip_key !== '0) begin bad++; $display("FAIL reset_cip_key: got %h want 0", cip_key); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_keygen();
        session_start(1'b1, 1'b0, 64'h0);
        total++; if (mode !== 3'd1) begin bad++; $display("FAIL keygen_mode: got %0d want 1", mode); end
        total++; if (ecc_start !== 1'b1) begin bad++; $display("FAIL keygen_ecc_start_hi: got %b want 1", ecc_start); end
        @(negedge clk);
        total++; if (ecc_start !== 1'b0) begin bad++; $display("FAIL keygen_ecc_start_lo: got %b want 0", ecc_start); end
        ecc_done = 1'b1; ecc_sk = KEY_A;
        @(negedge clk);
        ecc_done = 1'b0; ecc_sk = '0;
        total++; if (mode !== 3'd2) begin bad++; $display("FAIL keygen_ready: got %0d want 2", mode); end
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL keygen_key_valid: got %b want 1", key_valid); end
        total++; if (cip_key !== KEY_A) begin bad++; $display("FAIL keygen_cip_key: got %h want %h", cip_key, KEY_A); end
    endtask

    task automatic test_ecb();
        int errs = 0;
        core_mask = MASK_A;
        session_start(1'b1, 1'b0, 64'h0);
        total++; if (mode !== 3'd3) begin bad++; $display("FAIL ecb_stream_mode: got %0d want 3", mode); end
        total++; if (cip_encrypt !== 1'b1) begin bad++; $display("FAIL ecb_cip_encrypt: got %b want 1", cip_encrypt); end
        tx_q.delete();
        for (int i = 0; i < 16; i++) tx_q.push_back({32'hC0DE0000 + 32'(i), 32'h12345678 ^ 32'(i * 7)});
        stream_blocks(16, 0, 300);
        total++; if (rx_q.size() != 16) begin bad++; $display("FAIL ecb_out_count: got %0d want 16", rx_q.size()); end
        if (rx_q.size() == 16 && acc_cyc.size() == 16) begin
            total++; if (out_cyc[0] - acc_cyc[0] != 2 + LAT)
                begin bad++; $display("FAIL ecb_latency: got %0d want %0d", out_cyc[0] - acc_cyc[0], 2 + LAT); end
            total++; if (acc_cyc[15] - acc_cyc[0] != 15)
                begin bad++; $display("FAIL ecb_back_to_back: got span %0d want 15", acc_cyc[15] - acc_cyc[0]); end
            for (int i = 0; i < 16; i++) if (rx_q[i] !== (tx_q[i] ^ MASK_A)) errs++;
            total++; if (errs != 0) begin bad++; $display("FAIL ecb_data: got %0d wrong blocks want 0", errs); end
        end
        wait_mode(3'd2, 20);
        total++; if (mode !== 3'd2) begin bad++; $display("FAIL ecb_end_mode: got %0d want 2", mode); end
    endtask

    task automatic test_backpressure();
        int early = 0;
        int errs  = 0;
        core_mask = MASK_A;
        session_start(1'b1, 1'b0, 64'h0);
        tx_q.delete();
        for (int i = 0; i < 12; i++) tx_q.push_back(64'hBEEF000000000000 | 64'(i * 3 + 1));
        stream_blocks(12, 20, 300);
        foreach (acc_cyc[i]) if (acc_cyc[i] < 20) early++;
        total++; if (early != DEPTH) begin bad++; $display("FAIL bp_accept_limit: got %0d want %0d", early, DEPTH); end
        total++; if (rx_q.size() != 12) begin bad++; $display("FAIL bp_out_count: got %0d want 12", rx_q.size()); end
        if (rx_q.size() == 12) begin
            for (int i = 0; i < 12; i++) if (rx_q[i] !== (tx_q[i] ^ MASK_A)) errs++;
            total++; if (errs != 0) begin bad++; $display("FAIL bp_data: got %0d wrong blocks want 0", errs); end
        end
        wait_mode(3'd2, 20);
        total++; if (mode !== 3'd2) begin bad++; $display("FAIL bp_end_mode: got %0d want 2", mode); end
    endtask

    task automatic test_cbc_encrypt();
        logic [63:0] prev;
        core_mask = 64'h0;
        cbc_p[0] = 64'h1122334455667788; cbc_p[1] = 64'hFFEEDDCCBBAA9988;
        cbc_p[2] = 64'h0000000000000000; cbc_p[3] = 64'hDEADBEEFCAFEF00D;
        prev = IV_A;
        for (int i = 0; i < 4; i++) begin cbc_c[i] = cbc_p[i] ^ prev; prev = cbc_c[i]; end
        session_start(1'b1, 1'b1, IV_A);
        tx_q.delete();
        for (int i = 0; i < 4; i++) tx_q.push_back(cbc_p[i]);
        stream_blocks(4, 0, 200);
        total++; if (rx_q.size() != 4) begin bad++; $display("FAIL cbce_out_count: got %0d want 4", rx_q.size()); end
        if (rx_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                total++; if (rx_q[i] !== cbc_c[i])
                    begin bad++; $display("FAIL cbce_data%0d: got %h want %h", i, rx_q[i], cbc_c[i]); end
            end
            for (int i = 0; i < 3; i++) begin
                total++; if (acc_cyc[i+1] - acc_cyc[i] != LAT + 1)
                    begin bad++; $display("FAIL cbce_gap%0d: got %0d want %0d", i, acc_cyc[i+1] - acc_cyc[i], LAT + 1); end
            end
        end
        wait_mode(3'd2, 20);
    endtask

    task automatic test_cbc_decrypt();
        core_mask = 64'h0;
        session_start(1'b0, 1'b1, IV_A);
        total++; if (cip_encrypt !== 1'b0) begin bad++; $display("FAIL cbcd_cip_encrypt: got %b want 0", cip_encrypt); end
        tx_q.delete();
        for (int i = 0; i < 4; i++) tx_q.push_back(cbc_c[i]);
        stream_blocks(4, 0, 200);
        total++; if (rx_q.size() != 4) begin bad++; $display("FAIL cbcd_out_count: got %0d want 4", rx_q.size()); end
        if (rx_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                total++; if (rx_q[i] !== cbc_p[i])
                    begin bad++; $display("FAIL cbcd_data%0d: got %h want %h", i, rx_q[i], cbc_p[i]); end
            end
            total++; if (acc_cyc[3] - acc_cyc[0] != 3)
                begin bad++; $display("FAIL cbcd_back_to_back: got span %0d want 3", acc_cyc[3] - acc_cyc[0]); end
        end
        wait_mode(3'd2, 20);
        total++; if (mode !== 3'd2) begin bad++; $display("FAIL cbcd_end_mode: got %0d want 2", mode); end
    endtask

    task automatic test_reset_inflight();
        int accepted = 0;
        int late     = 0;
        core_mask = MASK_A;
        session_start(1'b1, 1'b0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 64'h5555000000000000 | 64'(k); in_last = 1'b0;
            #1;
            if (in_ready) accepted++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = '0;
        total++; if (accepted != 3) begin bad++; $display("FAIL rstfl_accepted: got %0d want 3", accepted); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (mode !== 3'd0) begin bad++; $display("FAIL rstfl_mode: got %0d want 0", mode); end
        total++; if (cip_valid !== 1'b0) begin bad++; $display("FAIL rstfl_cip_valid: got %b want 0", cip_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstfl_in_ready: got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstfl_out_valid: got %b want 0", out_valid); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rstfl_key_valid: got %b want 0", key_valid); end
        total++; if (cip_key !== '0) begin bad++; $display("FAIL rstfl_cip_key: got %h want 0", cip_key); end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid !== 1'b0 || cip_valid !== 1'b0) late++;
            @(negedge clk);
        end
        total++; if (late != 0) begin bad++; $display("FAIL rstfl_late_push: got %0d busy cycles want 0", late); end
    endtask

    task automatic test_bad_key();
        ecc_done = 1'b1; ecc_sk = KEY_A;
        @(negedge clk);
        ecc_done = 1'b0; ecc_sk = '0;
        total++; if (mode !== 3'd0 || key_valid !== 1'b0)
            begin bad++; $display("FAIL stray_done: got mode %0d key_valid %b want 0 0", mode, key_valid); end
        session_start(1'b1, 1'b0, 64'h0);
        total++; if (mode !== 3'd1) begin bad++; $display("FAIL badkey_keygen: got %0d want 1", mode); end
        @(negedge clk);
        ecc_done = 1'b1; ecc_sk = '0;
        @(negedge clk);
        ecc_done = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL badkey_err_hi: got %b want 1", err); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL badkey_key_valid: got %b want 0", key_valid); end
        total++; if (mode !== 3'd0) begin bad++; $display("FAIL badkey_mode: got %0d want 0", mode); end
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL badkey_err_lo: got %b want 0", err); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_encrypt = 1'b0; cbc_en = 1'b0; iv = '0;
        ecc_done = 1'b0; ecc_sk = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b1; core_mask = '0;
        test_reset();
        test_keygen();
        test_ecb();
        test_backpressure();
        test_cbc_encrypt();
        test_cbc_decrypt();
        test_reset_inflight();
        test_bad_key();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
